// File: rtl/sort_sched_pkg.sv
// Shared types and constants for the sort scheduler: sequencer states,
// the LOAD hold length and the requester-index width helper.
package sort_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int LOAD_CYCLES = 2;

    function automatic int id_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/sort_sched_rr_arbiter.sv
// Combinational round-robin priority: the first requester found searching
// circularly upward from ptr+1 wins, reported one-hot and encoded.
module rr_arbiter
    import sort_sched_pkg::*;
#(
    parameter int R  = 2,
    parameter int IW = id_w(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int off);
        int s;
        s = (int'(p) + off) % R;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = R; off >= 1; off--) begin
            if (req[rot_idx(ptr, off)]) begin
                grant                   = '0;
                grant[rot_idx(ptr, off)] = 1'b1;
                idx                     = rot_idx(ptr, off);
            end
        end
    end

endmodule

// File: rtl/sort_sched.sv
// Shares one Sort engine among R requesters: round-robin grant, operand latch,
// load/run sequencing of the sorter with a run-time watchdog, tagged response.
module sort_sched
    import sort_sched_pkg::*;
#(
    parameter int N       = 3,
    parameter int R       = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_valid,
    input  logic [R*4*N-1:0]     req_data,
    output logic [R-1:0]         req_ready,
    output logic                 sort_rst,
    output logic [N-1:0]         sort_x0,
    output logic [N-1:0]         sort_x1,
    output logic [N-1:0]         sort_x2,
    output logic [N-1:0]         sort_x3,
    input  logic                 sort_done,
    input  logic [N-1:0]         sort_s0,
    input  logic [N-1:0]         sort_s1,
    input  logic [N-1:0]         sort_s2,
    input  logic [N-1:0]         sort_s3,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [id_w(R)-1:0]   resp_id,
    output logic [4*N-1:0]       resp_s,
    output logic                 resp_err,
    output logic                 busy
);

    localparam int IW = id_w(R);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
    localparam logic [IW-1:0] PTR_RST   = IW'(R - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [IW-1:0]   id_q,    id_d;
    logic [4*N-1:0]  x_q,     x_d;
    logic [4*N-1:0]  s_q,     s_d;
    logic            err_q,   err_d;
    logic [CW-1:0]   tcnt_q,  tcnt_d;
    logic [LW-1:0]   lcnt_q,  lcnt_d;

    logic [R-1:0]    arb_grant;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(
        .R  (R),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            id_q    <= '0;
            x_q     <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            s_q     <= s_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        x_d       = x_q;
        s_d       = s_q;
        err_d     = err_q;
        tcnt_d    = tcnt_q;
        lcnt_d    = lcnt_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                req_ready = arb_grant;
                if (|arb_grant) begin
                    x_d     = req_data[int'(arb_idx)*4*N +: 4*N];
                    id_d    = arb_idx;
                    ptr_d   = arb_idx;
                    lcnt_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (lcnt_q == LOAD_LAST) begin
                    tcnt_d  = '0;
                    state_d = RUN;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            RUN: begin
                // A done arriving on the final allowed cycle still counts as success.
                if (sort_done) begin
                    s_d     = {sort_s3, sort_s2, sort_s1, sort_s0};
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == TO_LAST) begin
                    tcnt_d  = tcnt_q + 1'b1;
                    s_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sort_rst   = (state_q != RUN);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_s     = s_q;
    assign resp_err   = err_q;

    assign sort_x0 = x_q[0*N +: N];
    assign sort_x1 = x_q[1*N +: N];
    assign sort_x2 = x_q[2*N +: N];
    assign sort_x3 = x_q[3*N +: N];

endmodule

// File: doc/sort_sched.md
Name: sort_sched

Overview:
- Shares one Sort engine among R requesters. Each request is a 4-tuple of N-bit signed values.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the Sort engine: holds its active-high rst to load, releases it to run, waits for done.
- Returns the sorted tuple tagged with the requester index. A timeout guards a hung sorter.

Parameters:
- N, 3, element width in bits, passed to Sort.
- R, 2, number of requesters (2..8).
- TIMEOUT, 255, max RUN cycles before aborting with error (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  R  request pending, one bit per requester
- req_data  in  R*4*N  requester i occupies bits [i*4N +: 4N], element k at [k*N +: N]
- req_ready  out  R  one-hot grant; handshake when req_valid[i] and req_ready[i] are both 1
- sort_rst  out  1  to Sort rst, active-high
- sort_x0..sort_x3  out  N each  to Sort x0..x3
- sort_done  in  1  from Sort done
- sort_s0..sort_s3  in  N each  from Sort s0..s3
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  $clog2(R) (min 1)  index of the served requester
- resp_s  out  4*N  sorted tuple, s0 at [0 +: N]
- resp_err  out  1  timeout occurred; resp_s is 0
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, sort_rst=1, sort_x*=0.
  - resp_valid=0, resp_id=0, resp_s=0, resp_err=0, busy=0.
  - RR pointer=R-1, so requester 0 wins first; timeout counter=0.
  - Reset mid-operation aborts silently; no response is issued.
- IDLE:
  - sort_rst=1.
  - req_ready is the combinational one-hot grant: first i with req_valid[i], searching circularly from pointer+1.
  - On handshake: latch req_data slice into sort_x*, latch id, pointer←id, go to LOAD.
  - No valid requests: req_ready=0.
- LOAD: exactly 2 cycles; sort_rst=1, sort_x* stable, req_ready=0. Then go to RUN and clear the counter.
- RUN:
  - sort_rst=0; sort_x* held stable; sort_done sampled every cycle.
  - sort_done=1: latch sort_s0..s3 into resp_s, resp_err=0, go to RESP.
  - Otherwise counter+1. If the counter reaches TIMEOUT first: resp_s=0, resp_err=1, go to RESP.
  - If sort_done and timeout coincide, done wins.
- RESP:
  - resp_valid=1; resp_id, resp_s and resp_err held stable; sort_rst=1.
  - On resp_ready: clear resp_valid next cycle, return to IDLE.
  - A new grant is possible in the cycle after return.
- sort_done is ignored outside RUN.
- Requesters must hold req_data stable while req_valid=1. Withdrawing an unaccepted request is legal.
- Fairness: after a requester is served, every other valid requester is served before it again.
- Latency from handshake cycle to resp_valid: 1 + 2 + k, where k = RUN cycles until done.
- Widths: operands pass through untouched; no arithmetic on data. Counter width is $clog2(TIMEOUT+1).

Decomposition:
- Package sort_sched_pkg holds:
  - state enum {IDLE, LOAD, RUN, RESP};
  - LOAD_CYCLES=2;
  - width helper for the id (max(1, $clog2(R))).
- One sub-module, rr_arbiter: parameter R; inputs req, ptr; output one-hot grant and encoded index; purely combinational circular priority.

Test Plan:
- Single request: R=2, req0 = {-1,-2,3,2}, real Sort(N=3) attached.
  - Expect sort_rst high 2 cycles after grant, then low.
  - Expect resp_valid with resp_id=0, resp_s={-2,-1,2,3}, resp_err=0.
- Contention: req0 and req1 both valid from reset, req1 = {0,1,2,3}.
  - Grant order 0 then 1.
  - Re-asserting req0 during req1's service is served only after req1's response.
- Back-pressure: hold resp_ready=0 for 10 cycles.
  - resp_valid, resp_id and resp_s stay stable.
  - busy=1 and req_ready=0 throughout.
  - Release gives one handshake, then IDLE.
- Timeout: stub sorter with done stuck 0, TIMEOUT=5.
  - resp_err=1 and resp_s=0 after 1+2+5 cycles from handshake.
  - Next request still served normally.
- Done-at-timeout: stub asserts done on RUN cycle TIMEOUT.
  - resp_err=0 and stub's s values returned.
- Async reset mid-RUN: pull rst low between clock edges.
  - All outputs go to reset values immediately; sort_rst=1.
  - No response is emitted.
  - After release, requester 0 has priority.
